// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : RV32I MEM stage - loads/stores over a req/ready data bus,
//             produces the MEM/WB register set. Optional misalignment trap
//             enabled by defining MEM_MISALIGN_TRAP_EN.
//  Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_reg2,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_write,
    input  logic        ex_mem_mem_read,
    input  logic [2:0]  ex_mem_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_busy,
    output logic [31:0] mem_wb_result,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic        bus_error
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_LIM = TO_W'(TIMEOUT_CYCLES);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            rw_q, rw_d;
    logic            berr_q, berr_d;
    logic            mis_q, mis_d;

    logic        w_memop;
    logic        w_misal;
    logic        w_issue;
    logic        w_wait;
    logic        w_req;
    logic        w_timeout_hit;
    logic [1:0]  w_a;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wdata;
    logic [3:0]  w_be_store;

    assign w_memop = ex_mem_mem_read | ex_mem_mem_write;
    assign w_a     = ex_mem_alu_result[1:0];
    assign w_wait  = (state_q == S_WAIT);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misal = w_memop &
                     (((ex_mem_funct3[1:0] == 2'b01) & w_a[0]) |
                      ((ex_mem_funct3[1:0] == 2'b10) & (w_a != 2'b00)));
    assign misaligned = mis_q;
`else
    assign w_misal = 1'b0;
`endif

    assign w_issue       = (state_q == S_IDLE) & w_memop & ~stall & ~w_misal;
    assign w_timeout_hit = w_wait & ~dmem_ready & (cnt_q == TIMEOUT_LIM);
    assign w_req         = reset & (w_issue | w_wait);

    assign mem_busy   = (w_issue & ~dmem_ready) | (w_wait & ~dmem_ready & ~w_timeout_hit);
    assign dmem_req   = w_req;
    assign dmem_we    = w_req & ex_mem_mem_write & ~ex_mem_mem_read;
    assign dmem_addr  = {ex_mem_alu_result[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_be    = w_req ? (ex_mem_mem_read ? 4'b1111 : w_be_store) : 4'b0000;

    // Store lane placement; funct3[2] is irrelevant for stores.
    always_comb begin
        w_wdata    = ex_mem_reg2;
        w_be_store = 4'b1111;
        case (ex_mem_funct3[1:0])
            2'b00: begin
                w_wdata    = {4{ex_mem_reg2[7:0]}};
                w_be_store = 4'b0001 << w_a;
            end
            2'b01: begin
                w_wdata    = {2{ex_mem_reg2[15:0]}};
                w_be_store = 4'b0011 << {w_a[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_a)
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ex_mem_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        berr_d   = 1'b0;
        mis_d    = 1'b0;
        if ((w_issue & dmem_ready) | (w_wait & dmem_ready)) begin
            result_d = ex_mem_mem_read ? w_load : ex_mem_alu_result;
            rd_d     = ex_mem_rd;
            rw_d     = ex_mem_reg_write;
            state_d  = S_IDLE;
        end else if (w_issue) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            rw_d    = 1'b0;
        end else if (w_timeout_hit) begin
            berr_d  = 1'b1;
            rw_d    = 1'b0;
            state_d = S_IDLE;
        end else if (w_wait) begin
            cnt_d = cnt_q + 1'b1;
            rw_d  = 1'b0;
        end else if (w_misal & ~stall) begin
            mis_d = 1'b1;
            rw_d  = 1'b0;
        end else if (~w_memop & ~stall) begin
            result_d = ex_mem_alu_result;
            rd_d     = ex_mem_rd;
            rw_d     = ex_mem_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= 32'd0;
            rd_q     <= 5'd0;
            rw_q     <= 1'b0;
            berr_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            berr_q   <= berr_d;
            mis_q    <= mis_d;
        end
    end

    assign mem_wb_result    = result_q;
    assign mem_wb_rd        = rd_q;
    assign mem_wb_reg_write = rw_q;
    assign bus_error        = berr_q;

`ifndef MEM_MISALIGN_TRAP_EN
    logic w_unused;
    assign w_unused = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Scoreboard-based self-checking bench for mem_stage.
//  Revision : 1.0
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_reg2;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write;
    logic        ex_mem_mem_write;
    logic        ex_mem_mem_read;
    logic [2:0]  ex_mem_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        mem_busy;
    logic [31:0] mem_wb_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write;
    logic        bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] sb_q[$];

    mem_stage #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_reg2       (ex_mem_reg2),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_reg_write  (ex_mem_reg_write),
        .ex_mem_mem_write  (ex_mem_mem_write),
        .ex_mem_mem_read   (ex_mem_mem_read),
        .ex_mem_funct3     (ex_mem_funct3),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_rdata        (dmem_rdata),
        .dmem_ready        (dmem_ready),
        .mem_busy          (mem_busy),
        .mem_wb_result     (mem_wb_result),
        .mem_wb_rd         (mem_wb_rd),
        .mem_wb_reg_write  (mem_wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
        .misaligned        (misaligned),
`endif
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completing edge.
    task automatic do_op(input logic [31:0] alu, input logic [31:0] reg2, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic mr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int waits,
                         input logic [31:0] exp_res, input logic exp_rw,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_we);
        logic        memop;
        int          busy_n;
        logic [37:0] e;
        memop  = mw | mr;
        busy_n = 0;
        sb_q.push_back({exp_res, rd, exp_rw});
        ex_mem_alu_result = alu;
        ex_mem_reg2       = reg2;
        ex_mem_rd         = rd;
        ex_mem_reg_write  = rw;
        ex_mem_mem_write  = mw;
        ex_mem_mem_read   = mr;
        ex_mem_funct3     = f3;
        dmem_rdata        = rdata;
        dmem_ready        = memop && (waits == 0);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            if (mem_busy) busy_n++;
            if (k == 0) begin
                chk("req", dmem_req, memop);
                chk("be", dmem_be, exp_be);
                chk("we", dmem_we, exp_we);
                chk("addr", dmem_addr, {alu[31:2], 2'b00});
                if (memop) chk("wdata", dmem_wdata, exp_wd);
            end
            @(posedge clk); #1;
            if (k < waits) begin
                chk("bubble_rw", mem_wb_reg_write, 1'b0);
                dmem_ready = (k + 1 == waits);
            end
        end
        chk("busy_cycles", busy_n, memop ? waits : 0);
        e = sb_q.pop_front();
        chk("wb_result", mem_wb_result, e[37:6]);
        chk("wb_rd", mem_wb_rd, e[5:1]);
        chk("wb_rw", mem_wb_reg_write, e[0]);
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b0;
        dmem_ready       = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  seen;
        reset = 1'b0; stall = 1'b0;
        ex_mem_alu_result = '0; ex_mem_reg2 = '0; ex_mem_rd = '0; ex_mem_reg_write = 1'b0;
        ex_mem_mem_write = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_funct3 = '0;
        dmem_rdata = '0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", mem_wb_result, 32'd0);
        chk("rst_rd", mem_wb_rd, 5'd0);
        chk("rst_rw", mem_wb_reg_write, 1'b0);
        chk("rst_berr", bus_error, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        //     alu           reg2          rd  rw mw mr f3      rdata         w  exp_res       rw be       wdata         we
        do_op(32'h1234_5678, 32'h0,        5,  1, 0, 0, 3'b000, 32'h0,        0, 32'h1234_5678, 1, 4'b0000, 32'h0,        0);
        do_op(32'h0000_0103, 32'h0,        6,  1, 0, 1, 3'b000, 32'h80FF_FFFF, 3, 32'hFFFF_FF80, 1, 4'b1111, 32'h0,       0);
        do_op(32'h0000_0202, 32'h0000_ABCD, 0, 0, 1, 0, 3'b001, 32'h0,        0, 32'h0000_0202, 0, 4'b1100, 32'hABCD_ABCD, 1);
        do_op(32'h0000_0101, 32'h0,        7,  1, 0, 1, 3'b100, 32'h0000_9C00, 1, 32'h0000_009C, 1, 4'b1111, 32'h0,       0);
        do_op(32'h0000_0002, 32'h0,        8,  1, 0, 1, 3'b001, 32'h8001_1234, 2, 32'hFFFF_8001, 1, 4'b1111, 32'h0,       0);
        do_op(32'h0000_0000, 32'h0,        9,  1, 0, 1, 3'b101, 32'h1234_F00D, 0, 32'h0000_F00D, 1, 4'b1111, 32'h0,       0);
        do_op(32'h0000_0301, 32'h1122_335A, 0, 0, 1, 0, 3'b000, 32'h0,        1, 32'h0000_0301, 0, 4'b0010, 32'h5A5A_5A5A, 1);
        do_op(32'h0000_0400, 32'hCAFE_F00D, 0, 0, 1, 0, 3'b010, 32'h0,        0, 32'h0000_0400, 0, 4'b1111, 32'hCAFE_F00D, 1);
        do_op(32'h0000_0010, 32'h0,        10, 1, 1, 1, 3'b010, 32'h1111_2222, 1, 32'h1111_2222, 1, 4'b1111, 32'h0,       0);

        // Stall in IDLE with a pending LW: no request, MEM/WB frozen.
        ex_mem_alu_result = 32'h0000_0020; ex_mem_rd = 11; ex_mem_reg_write = 1'b1;
        ex_mem_mem_read = 1'b1; ex_mem_funct3 = 3'b010; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_req", dmem_req, 1'b0);
            chk("stall_busy", mem_busy, 1'b0);
            @(posedge clk); #1;
            chk("stall_hold_res", mem_wb_result, 32'h1111_2222);
            chk("stall_hold_rd", mem_wb_rd, 5'd10);
        end
        stall = 1'b0;
        do_op(32'h0000_0020, 32'h0, 11, 1, 0, 1, 3'b010, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0, 0);

        // Timeout: abort after five WAIT cycles with TIMEOUT_CYCLES=4.
        ex_mem_alu_result = 32'h0000_0040; ex_mem_rd = 12; ex_mem_reg_write = 1'b1;
        ex_mem_mem_read = 1'b1; ex_mem_funct3 = 3'b010; dmem_ready = 1'b0;
        edges = 0; seen = 0;
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (bus_error) seen = 1;
        end
        chk("to_seen", seen, 1'b1);
        chk("to_edges", edges, 6);
        chk("to_rw", mem_wb_reg_write, 1'b0);
        ex_mem_mem_read = 1'b0; ex_mem_reg_write = 1'b0;
        @(negedge clk);
        chk("to_idle_req", dmem_req, 1'b0);
        @(posedge clk); #1;
        chk("to_pulse_once", bus_error, 1'b0);

        // Reset mid-WAIT abandons the access.
        ex_mem_alu_result = 32'h0000_0080; ex_mem_rd = 13; ex_mem_reg_write = 1'b1;
        ex_mem_mem_read = 1'b1; ex_mem_funct3 = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rstw_req", dmem_req, 1'b0);
            @(posedge clk); #1;
        end
        chk("rstw_result", mem_wb_result, 32'd0);
        chk("rstw_rd", mem_wb_rd, 5'd0);
        chk("rstw_rw", mem_wb_reg_write, 1'b0);
        ex_mem_mem_read = 1'b0; ex_mem_reg_write = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rstw_idle_busy", mem_busy, 1'b0);
        @(posedge clk); #1;
        chk("rstw_no_wb", mem_wb_reg_write, 1'b0);
        do_op(32'hAAAA_5555, 32'h0, 31, 1, 0, 0, 3'b000, 32'h0, 0, 32'hAAAA_5555, 1, 4'b0000, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the RV32I pipeline. Consumes the EX/MEM register set produced by the execute stage.
- Performs loads and stores over a req/ready data-memory bus and produces the MEM/WB register set.
- Sources mem_wb_result, which feeds both the WB stage and the EX forwarding mux.
- Asserts mem_busy to freeze IF/ID/EX while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without dmem_ready before the access is aborted.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset; all state is cleared on a clk edge while reset=0.
- stall  in  1  external hold from the hazard unit.
- ex_mem_alu_result  in  32  effective address, or the ALU result for non-memory ops.
- ex_mem_reg2  in  32  store data.
- ex_mem_rd  in  5  destination register.
- ex_mem_reg_write  in  1  instruction writes rd.
- ex_mem_mem_write  in  1  store.
- ex_mem_mem_read  in  1  load.
- ex_mem_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word-aligned address, {alu_result[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data, valid with dmem_ready.
- dmem_ready  in  1  transaction complete.
- mem_busy  out  1  upstream freeze request (combinational).
- mem_wb_result  out  32  registered result.
- mem_wb_rd  out  5  registered rd.
- mem_wb_reg_write  out  1  registered write enable.
- bus_error  out  1  registered one-cycle pulse on timeout.

Behaviour:
- memop = ex_mem_mem_read | ex_mem_mem_write. If both are 1, treat as a read.
- Reset (reset=0 at an edge):
  - State goes to IDLE and the counter is cleared.
  - mem_wb_result=0, mem_wb_rd=0, mem_wb_reg_write=0, bus_error=0.
  - dmem_req is forced to 0 combinationally while reset=0.
  - Reset during WAIT abandons the transaction; no writeback occurs.
- FSM states: IDLE and WAIT.
- IDLE, no memop, stall=0: the next edge registers mem_wb_result=alu_result, rd, and reg_write. Latency is one cycle.
- IDLE, no memop, stall=1: MEM/WB registers hold their values.
- IDLE, memop, stall=0:
  - dmem_req=1 combinationally.
  - If dmem_ready=1 in the same cycle: complete at this edge and stay in IDLE (zero-wait access).
  - Otherwise go to WAIT with counter=0.
- IDLE, memop, stall=1: no request is issued and MEM/WB registers hold.
- WAIT:
  - dmem_req=1, and the address, data, and byte enables are held.
  - Upstream is frozen, so the ex_mem inputs are stable.
  - stall is ignored.
  - On dmem_ready: complete and return to IDLE.
  - Otherwise the counter increments.
  - When counter==TIMEOUT_CYCLES and dmem_ready=0: abort, bus_error=1 for one cycle, mem_wb_reg_write=0, return to IDLE.
- mem_busy = (IDLE & memop & ~stall & ~dmem_ready) | (WAIT & ~dmem_ready & ~timeout_hit).
- Bubble rule: every edge with mem_busy=1 writes mem_wb_reg_write=0. WB therefore never sees a duplicate or stale write.
- Load completion: mem_wb_result = extracted data, with rd and reg_write taken from the ex_mem inputs.
  - Byte: lane alu_result[1:0]; sign-extend for B, zero-extend for BU.
  - Halfword: lane alu_result[1]; sign-extend for H, zero-extend for HU.
- Store completion: mem_wb_result = alu_result and mem_wb_reg_write=ex_mem_reg_write (0 for stores).
- Store lanes:
  - B: be = 4'b0001<<addr[1:0], wdata = {4{byte}}.
  - H: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{half}}.
  - W: be = 4'b1111.
- Reads drive be=4'b1111.
- dmem_we=ex_mem_mem_write & ~ex_mem_mem_read.
- Non-request cycles drive dmem_we=0 and dmem_be=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is treated as misaligned.
  - No request is issued, and mem_busy stays 0.
  - The next edge writes mem_wb_reg_write=0 and pulses a 1-bit output misaligned=1 for one cycle.
  - The pipeline continues.
- Undefined: the misaligned port is absent. The low address bits are ignored for lane selection beyond the rules above, and the access proceeds normally.

Test Plan:
- Reset: hold reset=0 for 2 edges mid-WAIT -> dmem_req=0 while reset=0; all mem_wb outputs=0; state IDLE; no writeback.
- ALU passthrough: no memop, alu_result=32'h1234_5678, rd=5, reg_write=1 -> one edge later mem_wb_result=32'h1234_5678, rd=5, reg_write=1.
- LB with wait states: addr=32'h0000_0103, funct3=000, dmem_ready after 3 cycles, rdata=32'h80FF_FFFF -> mem_busy high for 3 cycles with mem_wb_reg_write=0 on each busy edge; then result=32'hFFFF_FF80.
- SH zero-wait: addr=32'h0000_0202, reg2=32'h0000_ABCD, dmem_ready same cycle -> be=4'b1100, wdata=32'hABCD_ABCD, we=1, mem_busy=0.
- Timeout: TIMEOUT_CYCLES=4 and dmem_ready never asserted -> bus_error pulses once after 5 WAIT cycles; mem_wb_reg_write=0; FSM returns to IDLE.
- Stall: stall=1 in IDLE with an LW pending -> no dmem_req and MEM/WB held; after stall=0, LW completes with rdata=32'hDEAD_BEEF.
